// File: rtl/spi_slave_rx.sv
// SPI mode-0 responder: oversamples sclk/mosi/load in the clk domain, receives
// a WIDTH-bit word on mosi and returns a WIDTH-bit word on miso, MSB first.
module spi_slave_rx #(
  parameter int WIDTH       = 13,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sclk,
  input  logic             mosi,
  input  logic             load,
  input  logic [WIDTH-1:0] tx_dat,
  output logic             miso,
  output logic [WIDTH-1:0] rx_dat,
  output logic             rx_valid,
  output logic             frm_err,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 2);

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    FRAME_END
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, load_sync;
  logic                   sclk_hist, mosi_hist, load_hist;
  logic                   sclk_rise, sclk_fall, load_rise, load_fall;
  logic [SYNC_STAGES:0]   settle;
  logic                   armed;

  logic [WIDTH-2:0]       tx_sh;
  logic [WIDTH-1:0]       rx_sh;
  logic [CW-1:0]          cnt;

  logic                   frame_start;
  logic                   cnt_full;

  // Synchronizers, one history flop per line, and registered edge pulses so an
  // edge is acted on in the cycle after it reaches the last sync stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      mosi_sync <= '0;
      load_sync <= '1;
      sclk_hist <= 1'b0;
      mosi_hist <= 1'b0;
      load_hist <= 1'b1;
      sclk_rise <= 1'b0;
      sclk_fall <= 1'b0;
      load_rise <= 1'b0;
      load_fall <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      load_sync <= {load_sync[SYNC_STAGES-2:0], load};
      sclk_hist <= sclk_sync[SYNC_STAGES-1];
      mosi_hist <= mosi_sync[SYNC_STAGES-1];
      load_hist <= load_sync[SYNC_STAGES-1];
      sclk_rise <= sclk_sync[SYNC_STAGES-1] & ~sclk_hist;
      sclk_fall <= ~sclk_sync[SYNC_STAGES-1] & sclk_hist;
      load_rise <= load_sync[SYNC_STAGES-1] & ~load_hist;
      load_fall <= ~load_sync[SYNC_STAGES-1] & load_hist;
    end
  end

  // A reset taken mid-frame leaves load low; arming only after load is seen
  // high with real samples keeps the rest of that frame from restarting us.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      settle <= '0;
      armed  <= 1'b0;
    end else begin
      settle <= {settle[SYNC_STAGES-1:0], 1'b1};
      if (settle[SYNC_STAGES] && load_hist) begin
        armed <= 1'b1;
      end
    end
  end

  assign frame_start = load_fall & armed;
  assign cnt_full    = (cnt == CW'(WIDTH));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    busy     = 1'b0;
    rx_valid = 1'b0;
    frm_err  = 1'b0;
    case (state_q)
      IDLE: begin
        if (frame_start) begin
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        busy = 1'b1;
        if (load_rise) begin
          state_d = FRAME_END;
        end
      end
      FRAME_END: begin
        rx_valid = cnt_full;
        frm_err  = ~cnt_full;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Load rising edge takes priority over any sclk edge seen in the same cycle;
  // rx_dat is written on entry to FRAME_END so it is already valid with the strobe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_sh  <= '0;
      rx_sh  <= '0;
      cnt    <= '0;
      miso   <= 1'b0;
      rx_dat <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          miso <= 1'b0;
          if (frame_start) begin
            tx_sh <= tx_dat[WIDTH-2:0];
            cnt   <= '0;
            miso  <= tx_dat[WIDTH-1];
          end
        end
        ACTIVE: begin
          if (load_rise) begin
            if (cnt_full) begin
              rx_dat <= rx_sh;
            end
          end else if (sclk_rise) begin
            rx_sh <= {rx_sh[WIDTH-2:0], mosi_hist};
            if (cnt != CW'(WIDTH + 1)) begin
              cnt <= cnt + 1'b1;
            end
          end else if (sclk_fall) begin
            tx_sh <= tx_sh << 1;
            miso  <= tx_sh[WIDTH-2];
          end
        end
        FRAME_END: begin
          miso <= 1'b0;
        end
        default: begin
          miso <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave_rx.sv
// Bench for spi_slave_rx: drives mode-0 frames on the pins and checks received
// words and error strobes against a queue of expected frame outcomes.
module tb_spi_slave_rx;

  localparam int WIDTH = 13;
  localparam int SYNC  = 2;
  localparam int HALF  = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             sclk = 1'b0;
  logic             mosi = 1'b0;
  logic             load = 1'b1;
  logic [WIDTH-1:0] tx_dat = '0;
  logic             miso;
  logic [WIDTH-1:0] rx_dat;
  logic             rx_valid;
  logic             frm_err;
  logic             busy;

  typedef struct {
    bit               is_err;
    logic [WIDTH-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int checks = 0;
  int passed = 0;

  spi_slave_rx #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .mosi(mosi), .load(load),
    .tx_dat(tx_dat), .miso(miso), .rx_dat(rx_dat), .rx_valid(rx_valid),
    .frm_err(frm_err), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Every strobe consumes one expected outcome; err entries carry the held rx_dat.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && (rx_valid === 1'b1 || frm_err === 1'b1)) begin
      checks++;
      if (rx_valid === 1'b1 && frm_err === 1'b1) begin
        $display("[TB] FAIL strobes: rx_valid and frm_err both high");
      end else if (exp_q.size() == 0) begin
        $display("[TB] FAIL unexpected_pulse: rx_valid=%b frm_err=%b expected none", rx_valid, frm_err);
      end else begin
        mon_e = exp_q.pop_front();
        if (frm_err !== mon_e.is_err) begin
          $display("[TB] FAIL pulse_kind: frm_err=%b expected %b", frm_err, mon_e.is_err);
        end else if (rx_dat !== mon_e.data) begin
          $display("[TB] FAIL pulse_data: rx_dat=%h expected %h", rx_dat, mon_e.data);
        end else begin
          passed++;
        end
      end
    end
  end

  task automatic push_exp(input bit is_err, input logic [WIDTH-1:0] data);
    exp_t e;
    e.is_err = is_err;
    e.data   = data;
    exp_q.push_back(e);
  endtask

  task automatic send_frame(input logic [31:0] word, input int nbits, input int rst_after,
                            input logic [WIDTH-1:0] tx_mid, input bit chg_tx,
                            output logic [31:0] miso_bits, output int busy_low);
    miso_bits = '0;
    busy_low  = 0;
    load = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      mosi = word[nbits-1-i];
      repeat (HALF) @(negedge clk);
      miso_bits = {miso_bits[30:0], miso};
      if (busy !== 1'b1) busy_low++;
      sclk = 1'b1;
      if (chg_tx && i == 5) tx_dat = tx_mid;
      repeat (HALF) @(negedge clk);
      sclk = 1'b0;
      if (i == rst_after) begin
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
    end
    repeat (HALF) @(negedge clk);
    load = 1'b1;
    mosi = 1'b0;
  endtask

  task automatic drain(input string name);
    repeat (12) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      $display("[TB] FAIL %s_missing_pulse: %0d outcomes pending, expected 0", name, exp_q.size());
      exp_q.delete();
    end else passed++;
  endtask

  task automatic check_rx(input string name, input logic [WIDTH-1:0] want);
    checks++;
    if (rx_dat !== want) $display("[TB] FAIL %s: rx_dat=%h expected %h", name, rx_dat, want);
    else passed++;
  endtask

  task automatic check_idle_miso(input string name);
    int bad = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (miso !== 1'b0 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) $display("[TB] FAIL %s: %0d idle cycles with miso/busy high, expected 0", name, bad);
    else passed++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks += 5;
    if (miso !== 1'b0) $display("[TB] FAIL reset_miso: got %b expected 0", miso); else passed++;
    if (rx_dat !== '0) $display("[TB] FAIL reset_rx_dat: got %h expected 0", rx_dat); else passed++;
    if (rx_valid !== 1'b0) $display("[TB] FAIL reset_rx_valid: got %b expected 0", rx_valid); else passed++;
    if (frm_err !== 1'b0) $display("[TB] FAIL reset_frm_err: got %b expected 0", frm_err); else passed++;
    if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", busy); else passed++;
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_good_frame();
    logic [31:0] mb;
    int bl;
    int lat = 0;
    tx_dat = 13'h06d9;
    push_exp(1'b0, 13'h02cc);
    send_frame(32'h02cc, WIDTH, -1, '0, 1'b0, mb, bl);
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      @(negedge clk);
      if (rx_valid === 1'b1) lat = k;
    end
    checks += 3;
    if (lat != SYNC + 2) $display("[TB] FAIL good_latency: %0d cycles, expected %0d", lat, SYNC + 2); else passed++;
    if (mb[WIDTH-1:0] !== 13'h06d9) $display("[TB] FAIL good_miso: got %h expected 06d9", mb[WIDTH-1:0]); else passed++;
    if (bl != 0) $display("[TB] FAIL good_busy: low at %0d bit samples, expected 0", bl); else passed++;
    drain("good");
    check_rx("good_rx_dat", 13'h02cc);
  endtask

  task automatic test_short_frame();
    logic [31:0] mb;
    int bl;
    push_exp(1'b1, 13'h02cc);
    send_frame(32'h0abc, 12, -1, '0, 1'b0, mb, bl);
    drain("short");
    check_rx("short_rx_held", 13'h02cc);
  endtask

  task automatic test_long_frame();
    logic [31:0] mb;
    int bl;
    push_exp(1'b1, 13'h02cc);
    send_frame(32'h3fff, 14, -1, '0, 1'b0, mb, bl);
    drain("long");
    check_rx("long_rx_held", 13'h02cc);
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] mb;
    int bl;
    tx_dat = 13'h1234;
    send_frame(32'h1234, WIDTH, 5, '0, 1'b0, mb, bl);
    drain("abort");
    check_rx("abort_rx_cleared", 13'h0000);
    push_exp(1'b0, 13'h0a5a);
    send_frame(32'h0a5a, WIDTH, -1, '0, 1'b0, mb, bl);
    drain("after_abort");
    check_rx("after_abort_rx", 13'h0a5a);
  endtask

  task automatic test_back_to_back();
    logic [31:0] mb1, mb2;
    int bl;
    tx_dat = 13'h1555;
    push_exp(1'b0, 13'h1555);
    send_frame(32'h1555, WIDTH, -1, 13'h0f0f, 1'b1, mb1, bl);
    repeat (4) @(negedge clk);
    tx_dat = 13'h0333;
    push_exp(1'b0, 13'h0aaa);
    send_frame(32'h0aaa, WIDTH, -1, 13'h1c71, 1'b1, mb2, bl);
    drain("b2b");
    check_rx("b2b_rx", 13'h0aaa);
    checks += 2;
    if (mb1[WIDTH-1:0] !== 13'h1555) $display("[TB] FAIL b2b_miso1: got %h expected 1555", mb1[WIDTH-1:0]); else passed++;
    if (mb2[WIDTH-1:0] !== 13'h0333) $display("[TB] FAIL b2b_miso2: got %h expected 0333", mb2[WIDTH-1:0]); else passed++;
  endtask

  task automatic test_zero_bit_frame();
    logic [31:0] mb;
    int bl;
    tx_dat = 13'h1fff;
    check_idle_miso("idle_miso_before");
    push_exp(1'b1, 13'h0aaa);
    send_frame(32'h0, 0, -1, '0, 1'b0, mb, bl);
    drain("zero_bit");
    check_rx("zero_bit_rx_held", 13'h0aaa);
    check_idle_miso("idle_miso_after");
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_short_frame();
    test_long_frame();
    test_reset_mid_frame();
    test_back_to_back();
    test_zero_bit_frame();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/spi_slave_rx.md
Name: spi_slave_rx

Overview:
SPI responder (slave) end of the board SPI link. It oversamples the externally driven sclk, mosi and load lines in the clk domain, and shifts a WIDTH-bit word in on mosi while shifting a WIDTH-bit word out on miso, MSB first (SPI mode 0). At frame end it presents the received word with a one-cycle valid strobe, or flags a framing error. It connects to the same load/mosi/miso/sclk pins that the spi block drives as initiator, so a board loopback tests both ends.

Parameters:
WIDTH, 13, bits per frame (2..32)
SYNC_STAGES, 2, synchronizer flops on sclk/mosi/load (2..3)

Ports:
clk  in  1  system clock (27 MHz on board)
rst_n  in  1  synchronous reset, active-low, sampled on posedge clk
sclk  in  1  SPI clock from initiator, asynchronous to clk
mosi  in  1  serial data from initiator
load  in  1  frame delimiter: low = frame active, rising edge = end of frame
tx_dat  in  WIDTH  word to send; captured at frame start
miso  out  1  serial data to initiator
rx_dat  out  WIDTH  last correctly framed received word
rx_valid  out  1  one-cycle pulse: rx_dat updated
frm_err  out  1  one-cycle pulse: frame ended with bit count != WIDTH
busy  out  1  high while frame active

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE; miso=0, rx_dat=0, rx_valid=0, frm_err=0, busy=0; shift registers, bit counter and sync/edge flops cleared. The sync flops for load reset to 1 so that no spurious edge is detected after reset.
- Input conditioning: sclk, mosi and load each pass through SYNC_STAGES flops, then one edge-history flop. An edge is detected in the cycle after it appears at the last sync stage.
- Pin-to-detect latency: SYNC_STAGES+1 clk cycles.
- The design requires each sclk high and low phase to last at least SYNC_STAGES+2 clk cycles. At 10 kHz SPI with a 27 MHz clk this holds.
- FSM states:
  - IDLE: busy=0, miso=0, sclk edges ignored. On load falling edge: tx_sh<=tx_dat, cnt<=0, miso<=tx_dat[WIDTH-1], go to ACTIVE.
  - ACTIVE: busy=1.
    - sclk rising edge: rx_sh<={rx_sh[WIDTH-2:0], mosi_sync}; cnt<=cnt+1, saturating at WIDTH+1.
    - sclk falling edge: tx_sh<={tx_sh[WIDTH-2:0],1'b0}; miso<=tx_sh[WIDTH-2]. After WIDTH bits have been sent, miso shows 0.
    - load rising edge: go to END.
  - END (one cycle): if cnt==WIDTH then rx_dat<=rx_sh and rx_valid=1; otherwise frm_err=1 and rx_dat is held. miso<=0. Go to IDLE.
- rx_valid and frm_err are asserted only in the END cycle and are never high together.
- More than WIDTH sclk rises in a frame: rx_sh keeps the last WIDTH bits, cnt saturates, the frame ends with frm_err.
- Zero-bit frame (load low then high with no sclk): frm_err pulses.
- Load rising edge and an sclk edge detected in the same cycle: the load edge wins and the sclk edge is discarded.
- Load falling edge and an sclk edge in the same cycle while IDLE: only the frame start is processed.
- tx_dat changes during ACTIVE have no effect on the frame in progress.
- Reset mid-frame: the block returns to IDLE immediately with no valid/err pulse. Remaining sclk edges are ignored until the next load falling edge.
- Glitch on load shorter than 1 clk: may be missed entirely. A glitch that is caught is treated as a frame of 0 bits, which gives frm_err.

Test Plan:
- Initiator sends 13'h2cc, tx_dat=13'h6d9, 13 mode-0 sclk cycles at 10 kHz -> rx_dat=13'h2cc; rx_valid pulses once, SYNC_STAGES+2 cycles after load rises; sampled miso bits = 13'h6d9 MSB-first; busy high throughout the frame.
- 12 sclk cycles, then load rises -> frm_err pulses once; rx_dat keeps its previous value 13'h2cc; rx_valid stays 0.
- 14 sclk cycles with stream 1,then 13'h1fff -> frm_err=1; rx_dat unchanged.
- rst_n low for 1 cycle after the 6th sclk, then a full frame of 13'h0a5a -> no pulse for the aborted frame; second frame gives rx_dat=13'h0a5a and rx_valid.
- Back-to-back frames 13'h1555 then 13'h0aaa, with load high for only 4 clk between them -> two rx_valid pulses with the correct values; tx_dat changed mid-frame does not affect the miso stream.
- Load low then high with no sclk -> frm_err=1; miso stays 0 while idle.
